// File: rtl/unsigned_divider_if.sv
// Operand/result bundle for the 4-bit unsigned divider: operands and enable in,
// registered result, status and pad-direction word out.
interface unsigned_divider_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/unsigned_divider.sv
// 4-bit unsigned divider: combinational restoring shift-subtract array from ui_in,
// single output register stage (one-cycle latency, one result per cycle).
module unsigned_divider (
    input  logic               clk,
    input  logic               rst,
    unsigned_divider_if.slave  bus
);

    logic [3:0] a_op;
    logic [3:0] b_op;
    logic [3:0] quo;
    logic [3:0] rem;
    logic       dbz;
    logic       unused_uio_in;

    logic [7:0] uo_p1;
    logic       dbz_p1;
    logic       vld_p1;

    assign a_op          = bus.ui_in[7:4];
    assign b_op          = bus.ui_in[3:0];
    assign unused_uio_in = ^bus.uio_in;
    assign dbz           = (b_op == 4'd0);

    // One restoring step: shift the next dividend bit into the 5-bit partial
    // remainder and subtract the divisor if it fits. Returns {quotient_bit, remainder}.
    // A kept remainder is always below the divisor, so 4 bits carry it forward.
    function automatic logic [4:0] div_stage(
        input logic [3:0] rem_in,
        input logic [3:0] divisor,
        input logic       dividend_bit
    );
        logic [4:0] shifted;
        shifted = {rem_in, dividend_bit};
        if (shifted >= {1'b0, divisor})
            div_stage = {1'b1, 4'(shifted - {1'b0, divisor})};
        else
            div_stage = {1'b0, shifted[3:0]};
    endfunction

    // Stage p0: combinational array, quotient MSB first
    always_comb begin
        logic [4:0] step;
        logic [3:0] part;
        part = 4'd0;
        step = 5'd0;
        quo  = 4'd0;
        rem  = 4'd0;
        for (int i = 3; i >= 0; i--) begin
            step   = div_stage(part, b_op, a_op[i]);
            quo[i] = step[4];
            part   = step[3:0];
        end
        rem = part;
        // Divide by zero already yields all-ones / dividend in the array; pin it explicitly.
        if (dbz) begin
            quo = 4'hF;
            rem = a_op;
        end
    end

    // Stage p1: output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uo_p1  <= 8'h00;
            dbz_p1 <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (bus.ena) begin
            uo_p1  <= {quo, rem};
            dbz_p1 <= dbz;
            vld_p1 <= 1'b1;
        end
    end

    assign bus.uo_out  = uo_p1;
    assign bus.uio_out = {6'b000000, vld_p1, dbz_p1};
    assign bus.uio_oe  = 8'b0000_0011;

endmodule

// File: tb/tb_unsigned_divider.sv
// Directed self-checking bench for unsigned_divider: reset, known quotients,
// divide-by-zero, enable hold, mid-stream reset and a full operand sweep.
module tb_unsigned_divider;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    unsigned_divider_if bus ();

    unsigned_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Apply operands between edges, then sample 1 time unit after the next rising edge.
    task automatic drive(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        bus.ui_in = {a, b};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (bus.uo_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_uo: got %h expected 00", bus.uo_out);
        end
        checks++;
        if (bus.uio_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_uio: got %h expected 00", bus.uio_out);
        end
        checks++;
        if (bus.uio_oe !== 8'h03) begin
            errors++;
            $display("FAIL reset_oe: got %h expected 03", bus.uio_oe);
        end
        // Clock edges with ena high while reset is held must not load anything
        bus.ena   = 1'b1;
        bus.ui_in = {4'd10, 4'd3};
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_held: got uo=%h uio=%h expected 00 00", bus.uo_out, bus.uio_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.uo_out !== 8'h31 || bus.uio_out !== 8'h02) begin
            errors++;
            $display("FAIL reset_release: got uo=%h uio=%h expected 31 02", bus.uo_out, bus.uio_out);
        end
    endtask

    task automatic test_directed;
        logic [3:0] va [5];
        logic [3:0] vb [5];
        logic [7:0] vq [5];
        va = '{4'd10, 4'd15, 4'd9, 4'd7, 4'd8};
        vb = '{4'd3,  4'd5,  4'd2, 4'd3, 4'd4};
        vq = '{8'h31, 8'h30, 8'h41, 8'h21, 8'h20};
        for (int i = 0; i < 5; i++) begin
            drive(va[i], vb[i]);
            checks++;
            if (bus.uo_out !== vq[i] || bus.uio_out !== 8'h02) begin
                errors++;
                $display("FAIL directed_%0d_%0d: got uo=%h uio=%h expected %h 02",
                         va[i], vb[i], bus.uo_out, bus.uio_out, vq[i]);
            end
        end
        // Boundary cases: A<B, A=0, B=1, A=B, 15/15
        va = '{4'd3,  4'd0,  4'd13, 4'd6,  4'd15};
        vb = '{4'd9,  4'd7,  4'd1,  4'd6,  4'd15};
        vq = '{8'h03, 8'h00, 8'hD0, 8'h10, 8'h10};
        for (int i = 0; i < 5; i++) begin
            drive(va[i], vb[i]);
            checks++;
            if (bus.uo_out !== vq[i] || bus.uio_out !== 8'h02) begin
                errors++;
                $display("FAIL boundary_%0d_%0d: got uo=%h uio=%h expected %h 02",
                         va[i], vb[i], bus.uo_out, bus.uio_out, vq[i]);
            end
        end
    endtask

    task automatic test_div_by_zero;
        drive(4'd5, 4'd0);
        checks++;
        if (bus.uo_out !== 8'hF5 || bus.uio_out !== 8'h03) begin
            errors++;
            $display("FAIL dbz_5_0: got uo=%h uio=%h expected F5 03", bus.uo_out, bus.uio_out);
        end
        drive(4'd0, 4'd7);
        checks++;
        if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'h02) begin
            errors++;
            $display("FAIL dbz_clear: got uo=%h uio=%h expected 00 02", bus.uo_out, bus.uio_out);
        end
    endtask

    task automatic test_enable_hold;
        drive(4'd10, 4'd3);
        checks++;
        if (bus.uo_out !== 8'h31) begin
            errors++;
            $display("FAIL hold_load: got %h expected 31", bus.uo_out);
        end
        @(negedge clk);
        bus.ena   = 1'b0;
        bus.ui_in = {4'd15, 4'd1};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.uo_out !== 8'h31 || bus.uio_out !== 8'h02 || bus.uio_oe !== 8'h03) begin
                errors++;
                $display("FAIL hold_cycle_%0d: got uo=%h uio=%h oe=%h expected 31 02 03",
                         i, bus.uo_out, bus.uio_out, bus.uio_oe);
            end
        end
        @(negedge clk);
        bus.ena = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.uo_out !== 8'hF0) begin
            errors++;
            $display("FAIL hold_resume: got %h expected F0", bus.uo_out);
        end
    endtask

    task automatic test_reset_midstream;
        drive(4'd7, 4'd3);
        checks++;
        if (bus.uo_out !== 8'h21) begin
            errors++;
            $display("FAIL mid_load: got %h expected 21", bus.uo_out);
        end
        bus.ui_in = {4'd9, 4'd2};
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'h00 || bus.uio_oe !== 8'h03) begin
            errors++;
            $display("FAIL mid_async: got uo=%h uio=%h oe=%h expected 00 00 03",
                     bus.uo_out, bus.uio_out, bus.uio_oe);
        end
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        bus.ui_in = {4'd8, 4'd4};
        #1;
        checks++;
        if (bus.uio_out !== 8'h00 || bus.uo_out !== 8'h00) begin
            errors++;
            $display("FAIL mid_pre_edge: got uo=%h uio=%h expected 00 00", bus.uo_out, bus.uio_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.uo_out !== 8'h20 || bus.uio_out !== 8'h02) begin
            errors++;
            $display("FAIL mid_first_edge: got uo=%h uio=%h expected 20 02", bus.uo_out, bus.uio_out);
        end
    endtask

    task automatic test_sweep;
        int a;
        int b;
        int q;
        int r;
        for (int i = 0; i < 256; i++) begin
            drive(4'(i >> 4), 4'(i & 15));
            a = i >> 4;
            b = i & 15;
            q = int'(bus.uo_out[7:4]);
            r = int'(bus.uo_out[3:0]);
            checks++;
            if (bus.uio_oe !== 8'h03) begin
                errors++;
                $display("FAIL sweep_oe_%0d: got %h expected 03", i, bus.uio_oe);
            end
            if (b != 0) begin
                checks++;
                if (q * b + r != a || r >= b || bus.uio_out !== 8'h02) begin
                    errors++;
                    $display("FAIL sweep_div_%0d_%0d: got q=%0d r=%0d uio=%h expected q*b+r=%0d r<%0d uio=02",
                             a, b, q, r, bus.uio_out, a, b);
                end
            end else begin
                checks++;
                if (q != 15 || r != a || bus.uio_out !== 8'h03) begin
                    errors++;
                    $display("FAIL sweep_dbz_%0d: got q=%0d r=%0d uio=%h expected 15 %0d 03",
                             a, q, r, bus.uio_out, a);
                end
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.ena    = 1'b0;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'hA5;
        test_reset();
        test_directed();
        test_div_by_zero();
        test_enable_hold();
        test_reset_midstream();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unsigned_divider.md
UNSIGNED_DIVIDER -- requirements
Module: unsigned_divider

Interface
REQ-001 The block SHALL have one clock and one reset; the reset SHALL be asynchronous and active-high.
REQ-002 Port list, one per line:
- clk  input  1  rising-edge clock; all state is on this clock.
- rst  input  1  asynchronous active-high reset.
- ena  input  1  clock enable; 1 = update registers, 0 = hold all registers.
- ui_in  input  8  operands: [7:4] = dividend A (unsigned 0..15), [3:0] = divisor B (unsigned 0..15).
- uio_in  input  8  unused; ignored.
- uo_out  output  8  result: [7:4] = quotient Q, [3:0] = remainder R.
- uio_out  output  8  status: [0] = div_by_zero flag, [1] = valid, [7:2] = 0.
- uio_oe  output  8  constant 8'b0000_0011 (bits 0 and 1 driven, rest input).
REQ-003 The block SHALL have no parameters; operand width is fixed at 4 bits.

Function
REQ-004 The block SHALL compute Q = A / B and R = A mod B, unsigned and truncating, with 0 <= R < B when B != 0.
REQ-005 The quotient SHALL be formed by a 4-stage restoring shift-subtract array, one stage per quotient bit, MSB first, using a 5-bit partial remainder per stage.
REQ-006 The division core SHALL be combinational from ui_in.
REQ-007 uo_out and uio_out[1:0] SHALL be registered, updated on each rising clk edge while ena = 1 and rst = 0.
REQ-008 Latency SHALL be exactly one clock: operands present before edge N appear on uo_out after edge N.
REQ-009 There SHALL be no handshake; a new operand pair may be applied every cycle, giving a throughput of one result per cycle.
REQ-010 When ena = 0, uo_out and uio_out SHALL hold their previous values regardless of ui_in.
REQ-011 When B = 0, the block SHALL register Q = 4'hF, R = A, and div_by_zero = 1.
REQ-012 When B != 0, the block SHALL register div_by_zero = 0.
REQ-013 Boundary results: A < B gives Q = 0, R = A; A = 0, B != 0 gives Q = 0, R = 0; B = 1 gives Q = A, R = 0; A = B != 0 gives Q = 1, R = 0; 15/15 gives Q = 1, R = 0.
REQ-014 valid SHALL go to 1 on the first enabled clock edge after reset deassertion and stay 1 until the next reset.
REQ-015 uio_oe SHALL be constant and unaffected by reset or ena.
REQ-016 Q and R SHALL never exceed 4 bits; no intermediate overflow may reach the outputs.

Reset
REQ-017 Asserting rst SHALL immediately, without a clock, force uo_out = 8'h00 and uio_out = 8'h00 (div_by_zero = 0, valid = 0).
REQ-018 Reset asserted mid-stream SHALL discard the in-flight result; after deassertion, the first enabled edge SHALL load the result for the ui_in value present at that edge.
REQ-019 Reset deassertion SHALL be synchronized to the clock such that no partial update occurs.

Verification
REQ-020 The bench SHALL cover these directed scenarios, sampling one clock after applying each operand pair with ena = 1:
- ui_in = {10,3} -> uo_out = 8'h31, div_by_zero = 0.
- ui_in = {15,5} -> 8'h30; ui_in = {9,2} -> 8'h41; ui_in = {7,3} -> 8'h21; ui_in = {8,4} -> 8'h20.
- ui_in = {5,0} -> uo_out = 8'hF5, uio_out[0] = 1; then ui_in = {0,7} -> uo_out = 8'h00, uio_out[0] = 0.
- Load {10,3}, drop ena, change ui_in to {15,1} for 3 cycles -> uo_out stays 8'h31; raise ena -> next edge gives 8'hF0.
- Assert rst between edges -> uo_out = 8'h00 and valid = 0 immediately; deassert -> valid = 1 after the first edge.
- Exhaustive sweep of all 256 ui_in values -> Q*B + R = A and R < B for every B != 0; REQ-011 holds for every B = 0; uio_oe = 8'h03 throughout.
